// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide with fixed XLEN+2 cycle latency.
module muldiv_unit #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) (
   input  logic            clk,
   input  logic            rstb,
   input  logic            Ex_MdStart,
   input  logic [2:0]      Ex_MdOp,
   input  logic [XLEN-1:0] Ex_MdA,
   input  logic [XLEN-1:0] Ex_MdB,
   input  logic [RD_W-1:0] Ex_MdRd,
   input  logic            Ex_MdFlush,
   output logic            Md_Busy,
   output logic            Md_Done,
   output logic [XLEN-1:0] Md_Result,
   output logic [RD_W-1:0] Md_Rd
);
   localparam int CW = $clog2(XLEN);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} stateType;
   stateType state, nextState;
   logic [2:0] op;
   logic [RD_W-1:0] rd;
   logic [XLEN-1:0] aMag, bMag, quot, rem, aMagIn, bMagIn, remNext, quotFix, remFix, result;
   logic [2*XLEN-1:0] prod, prodFix;
   logic [XLEN:0] mulSum, remShift;
   logic [CW-1:0] cnt;
   logic negA, negB, negAIn, negBIn, signA, signB, accept, lastStep, geq;
   assign signA = Ex_MdOp[2] ? !Ex_MdOp[0] : (Ex_MdOp[1:0] == 2'b01 || Ex_MdOp[1:0] == 2'b10);
   assign signB = Ex_MdOp[2] ? !Ex_MdOp[0] : (Ex_MdOp[1:0] == 2'b01);
   assign negAIn = signA && Ex_MdA[XLEN-1];
   assign negBIn = signB && Ex_MdB[XLEN-1];
   assign aMagIn = negAIn ? -Ex_MdA : Ex_MdA;
   assign bMagIn = negBIn ? -Ex_MdB : Ex_MdB;
   assign accept = Ex_MdStart && !Ex_MdFlush && (state == IDLE || state == DONE);
   assign lastStep = cnt == CW'(XLEN - 1);
   assign Md_Busy = state == CALC || state == FIX;
   assign Md_Done = state == DONE;
   always_ff @(posedge clk) begin
      if (rstb) state <= IDLE;
      else state <= nextState;
   end
   always_comb begin
      nextState = state;
      if (Ex_MdFlush) nextState = IDLE;
      else if (accept) nextState = CALC;
      else if (state == CALC) nextState = lastStep ? FIX : CALC;
      else if (state == FIX) nextState = DONE;
      else if (state == DONE) nextState = IDLE;
   end
   // Both datapaths step every CALC cycle; FIX picks the one the op needs.
   always_comb begin
      mulSum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, aMag} : '0);
      remShift = {rem, quot[XLEN-1]};
      geq = remShift >= {1'b0, bMag};
      remNext = geq ? remShift[XLEN-1:0] - bMag : remShift[XLEN-1:0];
      prodFix = (negA ^ negB) ? -prod : prod;
      quotFix = (bMag == '0) ? '1 : ((negA ^ negB) ? -quot : quot);
      remFix = negA ? -rem : rem;
      result = (op == 3'b000) ? prodFix[XLEN-1:0] : !op[2] ? prodFix[2*XLEN-1:XLEN] : !op[1] ? quotFix : remFix;
   end
   always_ff @(posedge clk) begin
      if (rstb) begin
         op <= '0;
         rd <= '0;
         aMag <= '0;
         bMag <= '0;
         negA <= 1'b0;
         negB <= 1'b0;
         cnt <= '0;
         prod <= '0;
         rem <= '0;
         quot <= '0;
         Md_Result <= '0;
         Md_Rd <= '0;
      end else if (accept) begin
         op <= Ex_MdOp;
         rd <= Ex_MdRd;
         aMag <= aMagIn;
         bMag <= bMagIn;
         negA <= negAIn;
         negB <= negBIn;
         cnt <= '0;
         prod <= {{XLEN{1'b0}}, bMagIn};
         rem <= '0;
         quot <= aMagIn;
      end else if (state == CALC) begin
         cnt <= cnt + CW'(1);
         prod <= {mulSum, prod[XLEN-1:1]};
         rem <= remNext;
         quot <= {quot[XLEN-2:0], geq};
      end else if (state == FIX && !Ex_MdFlush) begin
         Md_Result <= result;
         Md_Rd <= rd;
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed checks of muldiv_unit (XLEN 32 and 16) against an arithmetic model.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic rstb, flush, start32, start16;
   logic [2:0] op;
   logic [4:0] rd;
   logic [31:0] a32, b32, res32;
   logic [15:0] a16, b16, res16;
   logic busy32, done32, busy16, done16;
   logic [4:0] rdo32, rdo16;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(32), .RD_W(5)) dut32 (
      .clk(clk), .rstb(rstb), .Ex_MdStart(start32), .Ex_MdOp(op), .Ex_MdA(a32), .Ex_MdB(b32),
      .Ex_MdRd(rd), .Ex_MdFlush(flush), .Md_Busy(busy32), .Md_Done(done32), .Md_Result(res32), .Md_Rd(rdo32));
   muldiv_unit #(.XLEN(16), .RD_W(5)) dut16 (
      .clk(clk), .rstb(rstb), .Ex_MdStart(start16), .Ex_MdOp(op), .Ex_MdA(a16), .Ex_MdB(b16),
      .Ex_MdRd(rd), .Ex_MdFlush(flush), .Md_Busy(busy16), .Md_Done(done16), .Md_Result(res16), .Md_Rd(rdo16));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // RISC-V M semantics from plain integer arithmetic on sign/zero-extended operands.
   function automatic logic [63:0] refModel(input int w, input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
      longint mask, ua, ub, sa, sb, x, y, p, q, r;
      mask = (longint'(1) << w) - 1;
      ua = a & mask;
      ub = b & mask;
      sa = $signed(a << (64 - w)) >>> (64 - w);
      sb = $signed(b << (64 - w)) >>> (64 - w);
      if (!f[2]) begin
         p = (f == 3'b001) ? sa * sb : (f == 3'b010) ? sa * ub : ua * ub;
         return (f == 3'b000) ? (p & mask) : ((p >>> w) & mask);
      end
      x = f[0] ? ua : sa;
      y = f[0] ? ub : sb;
      if (y == 0) begin
         q = -1;
         r = x;
      end else if (!f[0] && x == -(longint'(1) << (w - 1)) && y == -1) begin
         q = x;
         r = 0;
      end else begin
         q = x / y;
         r = x % y;
      end
      return (f[1] ? r : q) & mask;
   endfunction

   // Caller is at a negedge; launches an op and follows it to Md_Done.
   task automatic runOp(input int w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r, input string tag);
      int n, busyCnt;
      logic [63:0] exp;
      exp = refModel(w, f, {32'h0, a}, {32'h0, b});
      op = f;
      rd = r;
      if (w == 32) begin
         a32 = a;
         b32 = b;
         start32 = 1'b1;
      end else begin
         a16 = a[15:0];
         b16 = b[15:0];
         start16 = 1'b1;
      end
      @(posedge clk);
      #1 start32 = 1'b0;
      start16 = 1'b0;
      busyCnt = 0;
      for (n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (w == 32 ? busy32 : busy16) busyCnt++;
         if (w == 32 ? done32 : done16) break;
      end
      check({tag, ".lat"}, 64'(n), 64'(w + 2));
      check({tag, ".busy"}, 64'(busyCnt), 64'(w + 1));
      check({tag, ".res"}, w == 32 ? {32'h0, res32} : {48'h0, res16}, exp);
      check({tag, ".rd"}, 64'(w == 32 ? rdo32 : rdo16), 64'(r));
   endtask

   initial begin
      int doneCnt, lat;
      logic [31:0] held, got;
      logic [4:0] heldRd;
      logic [31:0] ra, rb;
      rstb = 1'b1;
      flush = 1'b0;
      start32 = 1'b0;
      start16 = 1'b0;
      op = '0;
      rd = '0;
      a32 = '0;
      b32 = '0;
      a16 = '0;
      b16 = '0;
      repeat (3) @(negedge clk);
      check("rst.busy", 64'(busy32), 64'd0);
      check("rst.done", 64'(done32), 64'd0);
      check("rst.res", 64'(res32), 64'd0);
      check("rst.rd", 64'(rdo32), 64'd0);
      rstb = 1'b0;
      runOp(32, 3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, "mul");
      runOp(32, 3'b001, 32'h80000000, 32'h80000000, 5'd1, "mulh");
      runOp(32, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, "mulhu");
      runOp(32, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, "mulhsu");
      runOp(32, 3'b100, -32'sd7, 32'd2, 5'd4, "div");
      runOp(32, 3'b110, -32'sd7, 32'd2, 5'd6, "rem");
      runOp(32, 3'b101, 32'd100, 32'd7, 5'd7, "divu");
      runOp(32, 3'b111, 32'd100, 32'd7, 5'd8, "remu");
      runOp(32, 3'b101, 32'd5, 32'd0, 5'd9, "divu0");
      runOp(32, 3'b110, 32'd5, 32'd0, 5'd10, "rem0");
      runOp(32, 3'b100, -32'sd5, 32'd0, 5'd11, "divneg0");
      runOp(32, 3'b110, -32'sd5, 32'd0, 5'd12, "remneg0");
      runOp(32, 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd13, "divovf");
      runOp(32, 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd14, "removf");
      for (int i = 0; i < 40; i++) begin
         ra = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 3))
            0: rb = 32'd0;
            1: rb = $urandom_range(1, 15);
            2: rb = 32'hFFFFFFFF;
            default: rb = $urandom;
         endcase
         runOp(32, 3'($urandom_range(0, 7)), ra, rb, 5'($urandom), "rnd32");
      end
      @(negedge clk);
      check("done.pulse", 64'(done32), 64'd0);
      runOp(16, 3'b011, 32'h0000FFFF, 32'h0000FFFF, 5'd21, "mulhu16");
      for (int i = 0; i < 12; i++)
         runOp(16, 3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, 5'($urandom), "rnd16");
      // Flush in the 10th CALC cycle with a same-cycle start that must be ignored.
      held = res32;
      heldRd = rdo32;
      op = 3'b000;
      rd = 5'd30;
      a32 = 32'd3;
      b32 = 32'd5;
      start32 = 1'b1;
      @(posedge clk);
      #1 start32 = 1'b0;
      repeat (10) @(negedge clk);
      check("flush.busyPre", 64'(busy32), 64'd1);
      flush = 1'b1;
      start32 = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      start32 = 1'b0;
      @(negedge clk);
      check("flush.busy", 64'(busy32), 64'd0);
      check("flush.res", 64'(res32), 64'(held));
      check("flush.rd", 64'(rdo32), 64'(heldRd));
      runOp(32, 3'b101, 32'd100, 32'd7, 5'd17, "postflush");
      // Start pulsed mid-operation must not spawn a second completion.
      op = 3'b101;
      rd = 5'd18;
      a32 = 32'd100;
      b32 = 32'd7;
      start32 = 1'b1;
      @(posedge clk);
      #1 start32 = 1'b0;
      doneCnt = 0;
      lat = 0;
      got = '0;
      for (int n = 1; n <= 80; n++) begin
         @(negedge clk);
         if (n == 5) begin
            start32 = 1'b1;
            op = 3'b000;
            a32 = 32'd3;
            b32 = 32'd3;
         end else start32 = 1'b0;
         if (done32) begin
            doneCnt++;
            if (lat == 0) begin
               lat = n;
               got = res32;
            end
         end
      end
      check("busyStart.count", 64'(doneCnt), 64'd1);
      check("busyStart.lat", 64'(lat), 64'd34);
      check("busyStart.res", 64'(got), 64'd14);
      // Reset mid-CALC clears all outputs on the next edge.
      op = 3'b011;
      rd = 5'd25;
      a32 = $urandom;
      b32 = $urandom;
      start32 = 1'b1;
      @(posedge clk);
      #1 start32 = 1'b0;
      repeat (10) @(negedge clk);
      rstb = 1'b1;
      @(negedge clk);
      check("midRst.busy", 64'(busy32), 64'd0);
      check("midRst.done", 64'(done32), 64'd0);
      check("midRst.res", 64'(res32), 64'd0);
      check("midRst.rd", 64'(rdo32), 64'd0);
      rstb = 1'b0;
      doneCnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (done32) doneCnt++;
      end
      check("midRst.noDone", 64'(doneCnt), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
